// File: rtl/pe_pkg.sv
// Shared PE definitions: buffer geometry, datapath types and the drain FSM state type.
// Used by the reducer, the requantiser and the buffer drain.
package pe_pkg;

    localparam int unsigned ACC_W     = 36;  // accumulator width (signed)
    localparam int unsigned OUT_W     = 16;  // activation width (signed)
    localparam int unsigned NUM_ENTRY = 10;  // accumulation-buffer entries
    localparam int unsigned ADDR_W    = 7;   // reducer address width

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] act_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SEND,
        DONE
    } drain_state_e;

endpackage

// File: rtl/pe_requant.sv
// Combinational requantiser: turns a signed partial sum into a non-negative activation.
// It rounds half up while dropping SHIFT fractional bits, clamps negatives to 0 (ReLU)
// and saturates to the largest positive activation.
//   i_acc : signed accumulator value (ACC_W bits)
//   o_act : requantised activation (OUT_W bits, always >= 0)
module pe_requant #(
    parameter int unsigned ACC_W = pe_pkg::ACC_W,
    parameter int unsigned OUT_W = pe_pkg::OUT_W,
    parameter int unsigned SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_act
);

    // One extra bit keeps the rounding add free of overflow.
    localparam logic signed [ACC_W:0] RND =
        (SHIFT > 0) ? ((ACC_W + 1)'(1) << (SHIFT - 1)) : '0;
    localparam logic signed [ACC_W:0] MAX_POS =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};

    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rounded;

    always_comb begin
        wide    = $signed({i_acc[ACC_W-1], i_acc}) + RND;
        rounded = wide >>> SHIFT;
        if (rounded < 0) begin
            o_act = '0;
        end else if (rounded > MAX_POS) begin
            o_act = MAX_POS[OUT_W-1:0];
        end else begin
            o_act = rounded[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pe_buffer_drain.sv
// Drains the reducer's accumulation buffer after i_finish: snapshots every entry, requantises
// one entry per SCAN cycle and streams the results (optionally only non-zero ones) with their
// index over a valid/ready port. o_clear lets the reducer restart while the drain runs.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_finish      : buffer-final pulse from the reducer (captured only in IDLE)
//   i_buf         : reducer accumulation buffer
//   o_clear       : one-cycle pulse after capture
//   o_valid/i_ready, o_data, o_idx : output stream
//   o_busy        : not IDLE
//   o_done        : one-cycle pulse at end of drain
//   o_count       : entries transmitted in the current/last drain
//   o_overrun     : sticky, i_finish seen while not IDLE
module pe_buffer_drain
    import pe_pkg::*;
#(
    parameter int unsigned NUM_ENTRY = pe_pkg::NUM_ENTRY,
    parameter int unsigned ACC_W     = pe_pkg::ACC_W,
    parameter int unsigned OUT_W     = pe_pkg::OUT_W,
    parameter int unsigned SHIFT     = 8,
    parameter bit          SKIP_ZERO = 1'b1,
    parameter int unsigned IDX_W     = $clog2(NUM_ENTRY)
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_finish,
    input  logic [NUM_ENTRY-1:0][ACC_W-1:0]   i_buf,
    output logic                              o_clear,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [OUT_W-1:0]                  o_data,
    output logic [IDX_W-1:0]                  o_idx,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [IDX_W:0]                    o_count,
    output logic                              o_overrun
);

    drain_state_e                    state_q, state_d;
    logic [NUM_ENTRY-1:0][ACC_W-1:0] snap_q;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [OUT_W-1:0]                data_q;
    logic [IDX_W-1:0]                oidx_q;
    logic [IDX_W:0]                  count_q;
    logic                            overrun_q;
    logic                            clear_q;

    logic             capture;
    logic             load;
    logic             handshake;
    logic             last;
    logic [OUT_W-1:0] q;

    pe_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .i_acc (snap_q[idx_q]),
        .o_act (q)
    );

    assign last = (idx_q == IDX_W'(NUM_ENTRY - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture   = 1'b0;
        load      = 1'b0;
        handshake = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_finish) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (SKIP_ZERO && (q == '0)) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_ready) begin
                    handshake = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            oidx_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            clear_q <= capture;
            if (capture) begin
                snap_q  <= i_buf;
                count_q <= '0;
            end
            if (load) begin
                data_q <= q;
                oidx_q <= idx_q;
            end
            if (handshake) begin
                count_q <= count_q + 1'b1;
            end
            // Any finish outside IDLE (including the DONE->IDLE cycle) is dropped.
            if (i_finish && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign o_clear   = clear_q;
    assign o_valid   = (state_q == SEND);
    assign o_data    = data_q;
    assign o_idx     = oidx_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_count   = count_q;
    assign o_overrun = overrun_q;

endmodule
